// File: rtl/locked_reg_ctrl_if.sv
// Bus bundle for locked_reg_ctrl: key/write/lock requests in, protected value and status out.
interface locked_reg_ctrl_if #(parameter int WIDTH = 8);
  logic             key_valid;
  logic [WIDTH-1:0] key_data;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             lock_req;
  logic [WIDTH-1:0] data_out;
  logic             unlocked;
  logic             perm_locked;
  logic             violation;
  logic [7:0]       viol_cnt;

  modport master (
    output key_valid, key_data, wr_req, wr_data, lock_req,
    input  data_out, unlocked, perm_locked, violation, viol_cnt
  );

  modport slave (
    input  key_valid, key_data, wr_req, wr_data, lock_req,
    output data_out, unlocked, perm_locked, violation, viol_cnt
  );
endinterface

// File: rtl/locked_reg_ctrl.sv
// Key-protected register: two-word unlock opens a timed write window; lock_req makes it permanently read-only.
// Optional macro LOCKED_REG_VIOL_CNT_EN adds a saturating violation counter that forces PERM at MAX_VIOL.
//
// state  | meaning
// LOCKED | idle, waiting for KEY0
// ARMED  | KEY0 seen, waiting for KEY1
// OPEN   | writes accepted until win_cnt expires
// PERM   | permanently locked, left only through resetn
module locked_reg_ctrl #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] KEY0     = 8'hA5,
  parameter logic [WIDTH-1:0] KEY1     = 8'h5A,
  parameter int               WINDOW   = 16,
  parameter int               MAX_VIOL = 4
) (
  input logic              clk,
  input logic              resetn,
  locked_reg_ctrl_if.slave bus
);

  localparam int             CW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0]  WIN_LOAD = CW'(WINDOW - 1);

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARMED  = 2'd1,
    OPEN   = 2'd2,
    PERM   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] win_cnt;
  logic          win_zero;
  logic          viol_evt;
  logic          force_perm;

  assign win_zero = (win_cnt == '0);

  // All violation sources of one cycle merge into a single event.
  always_comb begin
    viol_evt = 1'b0;
    case (state)
      LOCKED: viol_evt = bus.wr_req | (bus.key_valid & (bus.key_data != KEY0));
      ARMED:  viol_evt = bus.wr_req | (bus.key_valid & (bus.key_data != KEY1));
      OPEN:   viol_evt = 1'b0;
      PERM:   viol_evt = bus.wr_req | bus.key_valid;
      default: viol_evt = 1'b0;
    endcase
  end

`ifdef LOCKED_REG_VIOL_CNT_EN
  logic [7:0] viol_cnt_q;

  assign force_perm   = viol_evt && (viol_cnt_q != 8'hFF) &&
                        ((int'(viol_cnt_q) + 1) == MAX_VIOL);
  assign bus.viol_cnt = viol_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      viol_cnt_q <= 8'd0;
    end else if (viol_evt && (viol_cnt_q != 8'hFF)) begin
      viol_cnt_q <= viol_cnt_q + 8'd1;
    end
  end
`else
  assign force_perm   = 1'b0;
  assign bus.viol_cnt = 8'd0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= LOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOCKED: begin
        if (bus.lock_req)                                 state_nxt = PERM;
        else if (bus.key_valid && (bus.key_data == KEY0)) state_nxt = ARMED;
      end
      ARMED: begin
        if (bus.lock_req)       state_nxt = PERM;
        else if (bus.key_valid) state_nxt = (bus.key_data == KEY1) ? OPEN : LOCKED;
      end
      OPEN: begin
        if (bus.lock_req)  state_nxt = PERM;
        else if (win_zero) state_nxt = LOCKED;
      end
      PERM:    state_nxt = PERM;
      default: state_nxt = LOCKED;
    endcase
    if (force_perm) state_nxt = PERM;
  end

  always_comb begin
    bus.unlocked    = (state == OPEN);
    bus.perm_locked = (state == PERM);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_cnt <= '0;
    end else if ((state == ARMED) && (state_nxt == OPEN)) begin
      win_cnt <= WIN_LOAD;
    end else if ((state == OPEN) && !win_zero) begin
      win_cnt <= win_cnt - 1'b1;
    end
  end

  // Writes are taken on any OPEN cycle, including the last one and the one that locks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.data_out <= '0;
    end else if ((state == OPEN) && bus.wr_req) begin
      bus.data_out <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.violation <= 1'b0;
    end else begin
      bus.violation <= viol_evt;
    end
  end

endmodule
